// File: rtl/servo_pkg.sv
// servo_pkg: opcodes, pulse-width size and FSM state types shared by the servo command sequencer.
package servo_pkg;
    localparam int PW_W = 12;
    localparam logic [7:0] OP_POS = 8'hB0;
    localparam logic [7:0] OP_STEP = 8'hB1;
    localparam logic [7:0] OP_STOP = 8'hB2;
    localparam logic [7:0] OP_SWEEP = 8'hA1;
    typedef enum logic {P_IDLE, P_OPERAND} parse_state_t;
    typedef enum logic [1:0] {M_HOLD, M_RAMP, M_SWEEP_OUT, M_SWEEP_BACK} motion_state_t;
endpackage

// File: rtl/servo_cmd_sequencer_if.sv
// servo_cmd_sequencer_if: byte stream from spi_slave (rx_valid is a 1-cycle strobe qualifying rx_data).
interface servo_cmd_sequencer_if;
    logic [7:0] rx_data;
    logic rx_valid;
    modport master(output rx_data, rx_valid);
    modport slave(input rx_data, rx_valid);
endinterface

// File: rtl/servo_pulse_gen.sv
// servo_pulse_gen: 1 us timebase, frame counter and registered servo pulse; width latched at each frame wrap.
module servo_pulse_gen
    import servo_pkg::*;
#(
    parameter int CLK_HZ = 25_000_000,
    parameter int FRAME_US = 20000,
    parameter int RST_PW = 1500
) (
    input logic clk,
    input logic rst,
    input logic [PW_W-1:0] pulse_us,
    output logic servo_pin,
    output logic frame_tick
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int DW = $clog2(DIV + 1);
    localparam int FW = $clog2(FRAME_US);
    logic [DW-1:0] div_q;
    logic [FW-1:0] us_q;
    logic [PW_W-1:0] pw_q;
    logic pin_q;
    logic us_tick;
    assign us_tick = div_q == DW'(DIV - 1);
    assign frame_tick = us_tick && us_q == FW'(FRAME_US - 1);
    assign servo_pin = pin_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            us_q <= '0;
            pw_q <= PW_W'(RST_PW);
            pin_q <= 1'b0;
        end else begin
            div_q <= us_tick ? '0 : div_q + 1'b1;
            us_q <= frame_tick ? '0 : us_q + FW'(us_tick);
            if (frame_tick) pw_q <= pulse_us;
            pin_q <= 32'(us_q) < 32'(pw_q);
        end
    end
endmodule

// File: rtl/servo_cmd_sequencer.sv
// servo_cmd_sequencer: parses SPI command bytes and ramps the servo pulse width toward each target.
// Define CMD_TIMEOUT_EN to abandon a missing operand after TIMEOUT_CYC clocks with a cmd_err pulse.
module servo_cmd_sequencer
    import servo_pkg::*;
#(
    parameter int CLK_HZ = 25_000_000,
    parameter int FRAME_US = 20000,
    parameter int MIN_US = 1000,
    parameter int MAX_US = 2000,
    parameter int DEF_STEP_US = 10
`ifdef CMD_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 250000
`endif
) (
    input logic clk,
    input logic rst,
    servo_cmd_sequencer_if.slave rx,
    output logic servo_pin,
    output logic [PW_W-1:0] pulse_us,
    output logic busy,
    output logic cmd_err,
    output logic led_verde,
    output logic led_verm
);
    localparam logic [PW_W-1:0] PMIN = PW_W'(MIN_US);
    localparam logic [PW_W-1:0] PMAX = PW_W'(MAX_US);
    localparam logic [PW_W-1:0] PMID = PW_W'((MIN_US + MAX_US) / 2);
    localparam logic [7:0] PSTEP = 8'(DEF_STEP_US);
    parse_state_t p_q, p_d;
    motion_state_t m_q, m_d;
    logic is_step_q, is_step_d, err_q, err_d;
    logic [PW_W-1:0] pulse_q, pulse_d, tgt_q, tgt_d;
    logic [7:0] step_q, step_d;
    logic cmd_pos, cmd_step, cmd_stop, cmd_sweep, frame_tick;
    logic signed [12:0] diff;
    logic [12:0] mag, pos_raw;
    servo_pulse_gen #(.CLK_HZ(CLK_HZ), .FRAME_US(FRAME_US), .RST_PW((MIN_US + MAX_US) / 2)) u_pg (
        .clk(clk), .rst(rst), .pulse_us(pulse_q), .servo_pin(servo_pin), .frame_tick(frame_tick)
    );
`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_q;
    always_ff @(posedge clk) begin
        if (rst) to_q <= '0;
        else to_q <= (p_q == P_OPERAND && !rx.rx_valid) ? to_q + 1'b1 : '0;
    end
`endif
    always_comb begin
        p_d = p_q;
        is_step_d = is_step_q;
        err_d = 1'b0;
        cmd_pos = 1'b0;
        cmd_step = 1'b0;
        cmd_stop = 1'b0;
        cmd_sweep = 1'b0;
        if (rx.rx_valid && p_q == P_OPERAND) begin
            p_d = P_IDLE;
            cmd_pos = !is_step_q;
            cmd_step = is_step_q;
        end else if (rx.rx_valid) begin
            if (rx.rx_data == OP_POS || rx.rx_data == OP_STEP) begin
                p_d = P_OPERAND;
                is_step_d = rx.rx_data == OP_STEP;
            end else begin
                cmd_stop = rx.rx_data == OP_STOP;
                cmd_sweep = rx.rx_data == OP_SWEEP;
                err_d = !(cmd_stop || cmd_sweep);
            end
`ifdef CMD_TIMEOUT_EN
        end else if (p_q == P_OPERAND && to_q == TO_LAST) begin
            p_d = P_IDLE;
            err_d = 1'b1;
`endif
        end
    end
    // The ramp sees the old target; a command arriving in the same cycle lands on top of it.
    always_comb begin
        m_d = m_q;
        pulse_d = pulse_q;
        tgt_d = tgt_q;
        step_d = step_q;
        diff = $signed({1'b0, tgt_q}) - $signed({1'b0, pulse_q});
        mag = diff[12] ? 13'(-diff) : 13'(diff);
        pos_raw = 13'(MIN_US) + {3'b000, rx.rx_data, 2'b00};
        if (frame_tick) begin
            pulse_d = mag <= {5'b0, step_q} ? tgt_q
                    : diff[12] ? pulse_q - {4'b0, step_q} : pulse_q + {4'b0, step_q};
            if (m_q != M_HOLD && pulse_d == tgt_q) begin
                m_d = m_q == M_SWEEP_OUT ? M_SWEEP_BACK : M_HOLD;
                tgt_d = m_q == M_SWEEP_OUT ? PMIN : tgt_q;
            end
        end
        if (cmd_pos) begin
            tgt_d = pos_raw > 13'(MAX_US) ? PMAX : pos_raw[PW_W-1:0];
            m_d = M_RAMP;
        end
        if (cmd_stop) begin
            tgt_d = pulse_d;
            m_d = M_HOLD;
        end
        if (cmd_sweep) begin
            tgt_d = PMAX;
            m_d = M_SWEEP_OUT;
        end
        if (cmd_step) step_d = rx.rx_data == 8'd0 ? 8'd1 : rx.rx_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= P_IDLE;
            is_step_q <= 1'b0;
            err_q <= 1'b0;
            m_q <= M_HOLD;
            pulse_q <= PMID;
            tgt_q <= PMID;
            step_q <= PSTEP;
        end else begin
            p_q <= p_d;
            is_step_q <= is_step_d;
            err_q <= err_d;
            m_q <= m_d;
            pulse_q <= pulse_d;
            tgt_q <= tgt_d;
            step_q <= step_d;
        end
    end
    assign pulse_us = pulse_q;
    assign cmd_err = err_q;
    assign busy = pulse_q != tgt_q || m_q == M_SWEEP_OUT || m_q == M_SWEEP_BACK;
    assign led_verde = !busy;
    assign led_verm = busy;
endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// tb_servo_cmd_sequencer: directed byte sequences against hand-computed pulse widths, targets and flags.
module tb_servo_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic servo_pin, busy, cmd_err, led_verde, led_verm;
    logic [11:0] pulse_us;
    int n_vec = 0;
    int n_err = 0;
    int sw1[8] = '{1252, 1502, 1752, 2000, 1750, 1500, 1250, 1000};
    int sw2[5] = '{1250, 1500, 1750, 2000, 1750};
    servo_cmd_sequencer_if rx_if();
    servo_cmd_sequencer #(
        .CLK_HZ(1_000_000), .FRAME_US(2100), .MIN_US(1000), .MAX_US(2000), .DEF_STEP_US(10)
`ifdef CMD_TIMEOUT_EN
        , .TIMEOUT_CYC(300)
`endif
    ) dut (
        .clk(clk), .rst(rst), .rx(rx_if), .servo_pin(servo_pin), .pulse_us(pulse_us),
        .busy(busy), .cmd_err(cmd_err), .led_verde(led_verde), .led_verm(led_verm)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        rx_if.rx_data = b;
        rx_if.rx_valid = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask
    task automatic next_frame();
        int k = 0;
        @(negedge clk);
        while (!dut.frame_tick && k < 2200) begin
            @(negedge clk);
            k++;
        end
        chk("frame_wait", 32'(k < 2200), 1);
        @(negedge clk);
    endtask
    task automatic ramp_chk(input string tag, input int exp);
        next_frame();
        chk(tag, 32'(pulse_us), exp);
    endtask
    task automatic count_high(output int n);
        n = 0;
        for (int i = 0; i < 2100; i++) begin
            n += int'(servo_pin);
            @(negedge clk);
        end
    endtask
    initial begin
        int hi;
        rx_if.rx_data = '0;
        rx_if.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(pulse_us), 1500);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_verde", 32'(led_verde), 1);
        chk("rst_verm", 32'(led_verm), 0);
        chk("rst_err", 32'(cmd_err), 0);
        chk("rst_pin", 32'(servo_pin), 0);
        rst = 1'b0;
        count_high(hi);
        chk("duty_1500", hi, 1500);
        chk("hold_1500", 32'(pulse_us), 1500);
        send(8'hB0);
        send(8'h00);
        chk("pos0_tgt", 32'(dut.tgt_q), 1000);
        chk("pos0_busy", 32'(busy), 1);
        chk("pos0_verm", 32'(led_verm), 1);
        ramp_chk("r10_a", 1490);
        ramp_chk("r10_b", 1480);
        send(8'hB1);
        send(8'hC8);
        ramp_chk("r200_a", 1280);
        ramp_chk("r200_b", 1080);
        ramp_chk("r200_end", 1000);
        chk("r200_busy", 32'(busy), 0);
        chk("r200_verde", 32'(led_verde), 1);
        next_frame();
        count_high(hi);
        chk("duty_1000", hi, 1000);
        send(8'hB1);
        send(8'h00);
        chk("step0_is1", 32'(dut.step_q), 1);
        send(8'hB0);
        send(8'hFF);
        chk("clamp_ff", 32'(dut.tgt_q), 2000);
        chk("clamp_busy", 32'(busy), 1);
        ramp_chk("r1_a", 1001);
        ramp_chk("r1_b", 1002);
        send(8'hB0);
        send(8'hFA);
        chk("clamp_fa", 32'(dut.tgt_q), 2000);
        send(8'hB0);
        send(8'hF9);
        chk("pos_f9", 32'(dut.tgt_q), 1996);
        send(8'hB2);
        chk("stop_tgt", 32'(dut.tgt_q), 1002);
        chk("stop_busy", 32'(busy), 0);
        ramp_chk("stop_hold", 1002);
        send(8'hB1);
        send(8'hFA);
        send(8'hA1);
        chk("sw_tgt", 32'(dut.tgt_q), 2000);
        chk("sw_busy", 32'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            ramp_chk("sw1", sw1[i]);
            if (i == 3) chk("sw_back_tgt", 32'(dut.tgt_q), 1000);
            if (i == 3) chk("sw_back_busy", 32'(busy), 1);
        end
        chk("sw_done_busy", 32'(busy), 0);
        ramp_chk("sw_done_hold", 1000);
        send(8'hA1);
        for (int i = 0; i < 5; i++) ramp_chk("sw2", sw2[i]);
        send(8'hA1);
        chk("restart_tgt", 32'(dut.tgt_q), 2000);
        ramp_chk("restart_a", 2000);
        ramp_chk("restart_b", 1750);
        send(8'hB2);
        chk("swstop_tgt", 32'(dut.tgt_q), 1750);
        chk("swstop_busy", 32'(busy), 0);
        ramp_chk("swstop_hold", 1750);
        send(8'hA1);
        ramp_chk("swpos_a", 2000);
        send(8'hB0);
        send(8'h7D);
        chk("swpos_tgt", 32'(dut.tgt_q), 1500);
        chk("swpos_busy", 32'(busy), 1);
        ramp_chk("swpos_b", 1750);
        ramp_chk("swpos_c", 1500);
        chk("swpos_idle", 32'(busy), 0);
        send(8'h55);
        chk("bad_err", 32'(cmd_err), 1);
        @(negedge clk);
        chk("bad_err_off", 32'(cmd_err), 0);
        chk("bad_tgt", 32'(dut.tgt_q), 1500);
        chk("bad_pulse", 32'(pulse_us), 1500);
        send(8'hB0);
        send(8'hB2);
        chk("operand_b2", 32'(dut.tgt_q), 1712);
        send(8'hB0);
        send(8'h7D);
        chk("pos_7d", 32'(dut.tgt_q), 1500);
`ifdef CMD_TIMEOUT_EN
        begin
            int first = -1;
            int pulses = 0;
            send(8'hB0);
            for (int i = 0; i < 320; i++) begin
                if (cmd_err && first < 0) first = i;
                pulses += int'(cmd_err);
                @(negedge clk);
            end
            chk("to_pulses", pulses, 1);
            chk("to_when", first, 300);
            send(8'hB0);
            send(8'h7D);
            chk("to_reparse", 32'(dut.tgt_q), 1500);
        end
`endif
        send(8'hB0);
        send(8'h00);
        ramp_chk("pre_rst", 1250);
        send(8'hB0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_pulse", 32'(pulse_us), 1500);
        chk("mrst_tgt", 32'(dut.tgt_q), 1500);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_pin", 32'(servo_pin), 0);
        chk("mrst_err", 32'(cmd_err), 0);
        chk("mrst_step", 32'(dut.step_q), 10);
        rst = 1'b0;
        send(8'h19);
        chk("mrst_opcode", 32'(cmd_err), 1);
        chk("mrst_no_pos", 32'(dut.tgt_q), 1500);
        send(8'hB0);
        send(8'h00);
        ramp_chk("mrst_step10", 1490);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
